telemetria_serial_n: RTL and testbench
======================================

// Module: telemetria_serial_n
// PURPOSE
//  Parametrised telemetry framer: snapshots N_CANAIS measurement words, sends them as uppercase hex-ASCII
//  over tx_serial_8N1 with separators and a terminator, handshaking byte by byte on tx_pronto.
//  Next generation of the 4-char datapath ASCII mux: any channel count and digit count, true A-F digits,
//  byte timeout. Sits between the level-measurement datapath and the serial transmitter.
// PARAMETERS
//  N_CANAIS        3        number of channels in the frame (>=1)
//  DIGITOS         3        hex digits per channel; channel width LARGURA = 4*DIGITOS
//  SEPARADOR       8'h2C    byte sent between channels (',')
//  TERMINADOR      8'h23    last byte of every frame ('#')
//  TIMEOUT_CICLOS  20000    max cycles waiting for tx_pronto per byte before abort
// PORTS
//  clock       in   1                    system clock; all logic rising-edge
//  zera_n      in   1                    reset, synchronous, active-low
//  iniciar     in   1                    start-frame request, sampled only in OCIOSO
//  medidas     in   N_CANAIS*LARGURA     channel c = medidas[c*LARGURA +: LARGURA]
//  tx_pronto   in   1                    1-cycle pulse from transmitter: byte finished
//  tx_partida  out  1                    1-cycle start pulse to transmitter
//  tx_dado     out  8                    byte to transmit, stable from tx_partida until tx_pronto
//  ocupado     out  1                    high while a frame is in progress
//  fim         out  1                    1-cycle pulse: frame completed normally
//  erro        out  1                    1-cycle pulse: frame aborted on timeout
//  db_estado   out  3                    current FSM state code
// BEHAVIOUR
//  Reset (zera_n=0 at an edge): state OCIOSO; tx_partida=0, tx_dado=8'h00, ocupado=0, fim=0, erro=0,
//   all counters 0, db_estado=3'd0. Reset mid-frame aborts at once; no fim/erro pulse.
//  States: OCIOSO(0) ENVIA(1) ESPERA(2) FIM(3) ERRO(4).
//  OCIOSO: iniciar=1 -> snapshot medidas, load first byte, -> ENVIA. Later medidas changes ignored.
//  ENVIA: tx_partida=1 for this single cycle -> ESPERA; timeout counter cleared. tx_pronto here ignored.
//  ESPERA: tx_pronto=1 -> if byte was TERMINADOR -> FIM else advance pointer, load next byte -> ENVIA.
//   Timeout counter reaches TIMEOUT_CICLOS-1 without tx_pronto -> ERRO.
//  FIM: fim=1 one cycle -> OCIOSO.  ERRO: erro=1 one cycle -> OCIOSO.  ocupado=1 in ENVIA/ESPERA.
//  Byte order: ch0..chN-1; per channel DIGITOS nibbles MSB first; SEPARADOR between channels, none after
//   last; then TERMINADOR. Length = N_CANAIS*DIGITOS + N_CANAIS-1 + 1 (12 bytes at defaults).
//  Nibble->ASCII: 0-9 -> 8'h30+n, 10-15 -> 8'h41+(n-10).
//  Latency: iniciar sampled at edge k -> tx_partida high in cycle after k; one byte per ENVIA/ESPERA pair.
//  iniciar while ocupado or in FIM/ERRO: ignored (not queued). Held iniciar restarts a frame from OCIOSO.
//  Counter widths: canal = max(1,$clog2(N_CANAIS)), digito = max(1,$clog2(DIGITOS)), timeout
//   = $clog2(TIMEOUT_CICLOS); no wrap beyond terminal values.
// CONFIGURATION
//  TELEMETRIA_CHECKSUM_EN defined: running XOR of all bytes before the checksum (digits+separators)
//   sent as 2 hex-ASCII chars (high nibble first) immediately before TERMINADOR; length +2.
//  Undefined: no checksum logic, frame ends channel data then TERMINADOR.
// STRUCTURE
//  Shared package aqua_pkg: ASCII constants (ASC_0, ASC_A, ASC_VIRGULA, ASC_HASH), FSM state encodings,
//   function nibble_ascii(4b)->8b.
//  One sub-module: hex_ascii (combinational nibble->ASCII), instanced once on the selected nibble.
//  Byte pointer = {fase, canal, digito}; fase in {DADO, SEP, CHK_H, CHK_L, TERM}.
// TESTING
//  T1 defaults, ch0=0A3 ch1=1F0 ch2=000, tx_pronto 5 cycles after each partida -> bytes
//     30 41 33 2C 31 46 30 2C 30 30 30 23, then fim pulse, ocupado low.
//  T2 same stimulus with TELEMETRIA_CHECKSUM_EN -> ...30 30 30 33 35 23 (checksum 8'h35), 14 bytes.
//  T3 change medidas and pulse iniciar mid-frame -> frame bytes unchanged from snapshot, no restart.
//  T4 withhold tx_pronto after 3rd byte -> erro pulse exactly TIMEOUT_CICLOS cycles after ESPERA entry, OCIOSO.
//  T5 zera_n=0 during 5th byte -> next cycle tx_partida=0, ocupado=0, db_estado=0, no fim/erro.
//  T6 N_CANAIS=1, DIGITOS=4, ch0=FFFF -> 46 46 46 46 23, no separator.

Source files
------------

// File: rtl/aqua_pkg.sv
// Shared definitions for the telemetry framer: ASCII constants, FSM and byte-phase
// encodings, and the nibble-to-ASCII helper.
package aqua_pkg;

  localparam logic [7:0] ASC_0       = 8'h30;
  localparam logic [7:0] ASC_A       = 8'h41;
  localparam logic [7:0] ASC_VIRGULA = 8'h2C;
  localparam logic [7:0] ASC_HASH    = 8'h23;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ENVIA  = 3'd1,
    ESPERA = 3'd2,
    FIM    = 3'd3,
    ERRO   = 3'd4
  } estado_t;

  // Which kind of byte the frame pointer currently addresses
  typedef enum logic [2:0] {
    F_DADO  = 3'd0,
    F_SEP   = 3'd1,
    F_CHK_H = 3'd2,
    F_CHK_L = 3'd3,
    F_TERM  = 3'd4
  } fase_t;

  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASC_0 + 8'(n);
    else           return ASC_A + 8'(n - 4'd10);
  endfunction

endpackage

// File: rtl/telemetria_serial_n_if.sv
// Byte handshake between the telemetry framer (master) and the serial transmitter (slave).
interface telemetria_serial_n_if;
  logic       tx_partida;
  logic [7:0] tx_dado;
  logic       tx_pronto;

  modport master (output tx_partida, output tx_dado, input tx_pronto);
  modport slave  (input tx_partida, input tx_dado, output tx_pronto);
endinterface

// File: rtl/hex_ascii.sv
// Combinational conversion of one hex nibble to its uppercase ASCII character.
module hex_ascii
  import aqua_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);
  assign ascii_c = nibble_ascii(nibble);
endmodule

// File: rtl/telemetria_serial_n.sv
// Telemetry framer: snapshots N_CANAIS words and sends them as hex-ASCII bytes with separators
// and a terminator. Define TELEMETRIA_CHECKSUM_EN to append an XOR checksum before the terminator.
module telemetria_serial_n
  import aqua_pkg::*;
#(
  parameter int unsigned N_CANAIS       = 3,
  parameter int unsigned DIGITOS        = 3,
  parameter logic [7:0]  SEPARADOR      = ASC_VIRGULA,
  parameter logic [7:0]  TERMINADOR     = ASC_HASH,
  parameter int unsigned TIMEOUT_CICLOS = 20000
) (
  input  logic                            clock,
  input  logic                            zera_n,
  input  logic                            iniciar,
  input  logic [N_CANAIS*4*DIGITOS-1:0]   medidas,
  telemetria_serial_n_if.master           tx,
  output logic                            ocupado,
  output logic                            fim,
  output logic                            erro,
  output logic [2:0]                      db_estado
);

  localparam int unsigned LARGURA = 4 * DIGITOS;
  localparam int unsigned TOTAL   = N_CANAIS * LARGURA;
  localparam int unsigned CW      = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
  localparam int unsigned DW      = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam int unsigned TW      = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam int unsigned NC2     = 2 ** CW;
  localparam int unsigned ND2     = 2 ** DW;

  localparam logic [CW-1:0] CANAL_ULT = CW'(N_CANAIS - 1);
  localparam logic [DW-1:0] DIG_ULT   = DW'(DIGITOS - 1);
  localparam logic [TW-1:0] TEMPO_ULT = TW'(TIMEOUT_CICLOS - 1);

`ifdef TELEMETRIA_CHECKSUM_EN
  localparam fase_t FASE_APOS_DADOS = F_CHK_H;
`else
  localparam fase_t FASE_APOS_DADOS = F_TERM;
`endif

  estado_t          estado, estado_prox;
  fase_t            fase, fase_prox;
  logic [CW-1:0]    canal, canal_prox;
  logic [DW-1:0]    digito, digito_prox;
  logic [TW-1:0]    tempo;
  logic [TOTAL-1:0] snapshot;
  logic [7:0]       dado;
  logic             partida, partida_prox;
  logic             ocupado_prox, fim_prox, erro_prox;
  logic             inicio_c, avanca_c, carrega_c;

  logic [TOTAL-1:0]   fonte_c;
  logic [LARGURA-1:0] canais_c [NC2];
  logic [LARGURA-1:0] palavra_c;
  logic [3:0]         digitos_c [ND2];
  logic [3:0]         nibble_c;
  logic [7:0]         ascii_c;
  logic [7:0]         byte_prox_c;

`ifdef TELEMETRIA_CHECKSUM_EN
  logic [7:0] chk;
`endif

  assign inicio_c  = (estado == OCIOSO) && iniciar;
  assign avanca_c  = (estado == ESPERA) && tx.tx_pronto && (fase != F_TERM);
  assign carrega_c = inicio_c || avanca_c;

  // State register; outputs are registered from the next-state decode
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      estado  <= OCIOSO;
      partida <= 1'b0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
      erro    <= 1'b0;
    end else begin
      estado  <= estado_prox;
      partida <= partida_prox;
      ocupado <= ocupado_prox;
      fim     <= fim_prox;
      erro    <= erro_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (iniciar) estado_prox = ENVIA;
      ENVIA:   estado_prox = ESPERA;
      ESPERA: begin
        if (tx.tx_pronto)            estado_prox = (fase == F_TERM) ? FIM : ENVIA;
        else if (tempo == TEMPO_ULT) estado_prox = ERRO;
      end
      FIM:     estado_prox = OCIOSO;
      ERRO:    estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    partida_prox = 1'b0;
    ocupado_prox = 1'b0;
    fim_prox     = 1'b0;
    erro_prox    = 1'b0;
    case (estado_prox)
      ENVIA:   begin partida_prox = 1'b1; ocupado_prox = 1'b1; end
      ESPERA:  ocupado_prox = 1'b1;
      FIM:     fim_prox = 1'b1;
      ERRO:    erro_prox = 1'b1;
      default: ;
    endcase
  end

  // Frame pointer successor: digits, separator, optional checksum, terminator
  always_comb begin
    fase_prox   = fase;
    canal_prox  = canal;
    digito_prox = digito;
    if (inicio_c) begin
      fase_prox   = F_DADO;
      canal_prox  = '0;
      digito_prox = '0;
    end else if (avanca_c) begin
      case (fase)
        F_DADO: begin
          if (digito == DIG_ULT) begin
            digito_prox = '0;
            fase_prox   = (canal == CANAL_ULT) ? FASE_APOS_DADOS : F_SEP;
          end else begin
            digito_prox = digito + DW'(1);
          end
        end
        F_SEP: begin
          fase_prox  = F_DADO;
          canal_prox = canal + CW'(1);
        end
        F_CHK_H: fase_prox = F_CHK_L;
        F_CHK_L: fase_prox = F_TERM;
        default: fase_prox = fase;
      endcase
    end
  end

  // The first byte comes straight from medidas, later ones from the snapshot
  assign fonte_c = (estado == OCIOSO) ? medidas : snapshot;

  for (genvar c = 0; c < NC2; c++) begin : g_canal
    if (c < N_CANAIS) begin : g_usado
      assign canais_c[c] = fonte_c[c*LARGURA +: LARGURA];
    end else begin : g_vazio
      assign canais_c[c] = '0;
    end
  end

  assign palavra_c = canais_c[canal_prox];

  for (genvar d = 0; d < ND2; d++) begin : g_dig
    if (d < DIGITOS) begin : g_usado
      assign digitos_c[d] = palavra_c[(DIGITOS-1-d)*4 +: 4];
    end else begin : g_vazio
      assign digitos_c[d] = '0;
    end
  end

  always_comb begin
    nibble_c = digitos_c[digito_prox];
`ifdef TELEMETRIA_CHECKSUM_EN
    if (fase_prox == F_CHK_H)      nibble_c = chk[7:4];
    else if (fase_prox == F_CHK_L) nibble_c = chk[3:0];
`endif
  end

  hex_ascii u_hex_ascii (
    .nibble  (nibble_c),
    .ascii_c (ascii_c)
  );

  always_comb begin
    case (fase_prox)
      F_SEP:   byte_prox_c = SEPARADOR;
      F_TERM:  byte_prox_c = TERMINADOR;
      default: byte_prox_c = ascii_c;
    endcase
  end

  // Datapath: snapshot, pointer, byte register, timeout and checksum
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      snapshot <= '0;
      fase     <= F_DADO;
      canal    <= '0;
      digito   <= '0;
      tempo    <= '0;
      dado     <= 8'h00;
`ifdef TELEMETRIA_CHECKSUM_EN
      chk      <= 8'h00;
`endif
    end else begin
      if (inicio_c)  snapshot <= medidas;
      if (carrega_c) dado     <= byte_prox_c;
      fase   <= fase_prox;
      canal  <= canal_prox;
      digito <= digito_prox;
      if (estado != ESPERA)        tempo <= '0;
      else if (tempo != TEMPO_ULT) tempo <= tempo + TW'(1);
`ifdef TELEMETRIA_CHECKSUM_EN
      if (inicio_c)
        chk <= byte_prox_c;
      else if (avanca_c && (fase_prox == F_DADO || fase_prox == F_SEP))
        chk <= chk ^ byte_prox_c;
`endif
    end
  end

  assign tx.tx_partida = partida;
  assign tx.tx_dado    = dado;
  assign db_estado     = 3'(estado);

endmodule

// File: tb/tb_telemetria_serial_n.sv
// Self-checking bench for telemetria_serial_n: a default instance and an N_CANAIS=1/DIGITOS=4
// instance, driven by a byte-level transmitter model and checked against a frame model.
module tb_telemetria_serial_n;

  localparam int TIMEOUT = 20000;

  logic        clock = 1'b0;
  logic        zera_n;
  logic        iniciar;
  logic        pronto;
  logic        sel;
  logic [35:0] medidas_a;
  logic [15:0] medidas_b;

  logic       ocupado_a, fim_a, erro_a, ocupado_b, fim_b, erro_b;
  logic [2:0] estado_a, estado_b;

  logic       s_partida, s_ocupado, s_fim, s_erro;
  logic [7:0] s_dado;
  logic [2:0] s_estado;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  telemetria_serial_n_if txa ();
  telemetria_serial_n_if txb ();

  always #5 clock = ~clock;

  telemetria_serial_n #(.TIMEOUT_CICLOS(TIMEOUT)) dut_a (
    .clock     (clock),
    .zera_n    (zera_n),
    .iniciar   (iniciar & ~sel),
    .medidas   (medidas_a),
    .tx        (txa),
    .ocupado   (ocupado_a),
    .fim       (fim_a),
    .erro      (erro_a),
    .db_estado (estado_a)
  );

  telemetria_serial_n #(.N_CANAIS(1), .DIGITOS(4), .TIMEOUT_CICLOS(TIMEOUT)) dut_b (
    .clock     (clock),
    .zera_n    (zera_n),
    .iniciar   (iniciar & sel),
    .medidas   (medidas_b),
    .tx        (txb),
    .ocupado   (ocupado_b),
    .fim       (fim_b),
    .erro      (erro_b),
    .db_estado (estado_b)
  );

  assign txa.tx_pronto = pronto & ~sel;
  assign txb.tx_pronto = pronto & sel;

  assign s_partida = sel ? txb.tx_partida : txa.tx_partida;
  assign s_dado    = sel ? txb.tx_dado    : txa.tx_dado;
  assign s_ocupado = sel ? ocupado_b      : ocupado_a;
  assign s_fim     = sel ? fim_b          : fim_a;
  assign s_erro    = sel ? erro_b         : erro_a;
  assign s_estado  = sel ? estado_b       : estado_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hex_char(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  // Expected frame from the channel words: MSB-first hex digits, commas, optional XOR, '#'
  task automatic build(input logic [63:0] m, input int n, input int d);
    logic [7:0] x;
    logic [7:0] b;
    int v;
    exp_q.delete();
    x = 8'h00;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < d; k++) begin
        v = int'((m >> (4 * (c * d + d - 1 - k))) & 64'hF);
        b = hex_char(v);
        exp_q.push_back(b);
        x = x ^ b;
      end
      if (c < n - 1) begin
        exp_q.push_back(8'h2C);
        x = x ^ 8'h2C;
      end
    end
`ifdef TELEMETRIA_CHECKSUM_EN
    exp_q.push_back(hex_char(int'(x) / 16));
    exp_q.push_back(hex_char(int'(x) % 16));
`endif
    exp_q.push_back(8'h23);
  endtask

  // Runs one frame; corte = byte index whose tx_pronto is withheld, reinicio = byte index
  // during which reset is asserted (-1 disables either)
  task automatic run_frame(input int dly, input bit muda, input int corte, input int reinicio);
    int  nb;
    bit  visto;
    nb = exp_q.size();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("ocupado_inicio", s_ocupado, 1);
    for (int i = 0; i < nb; i++) begin
      check("partida", s_partida, 1);
      check("estado_envia", s_estado, 1);
      check("dado", s_dado, exp_q[i]);
      @(negedge clock);
      check("partida_1ciclo", s_partida, 0);
      if (i == corte) begin
        check("estado_espera", s_estado, 2);
        repeat (TIMEOUT - 1) @(negedge clock);
        check("erro_cedo", s_erro, 0);
        @(negedge clock);
        check("erro", s_erro, 1);
        check("estado_erro", s_estado, 4);
        check("fim_no_erro", s_fim, 0);
        @(negedge clock);
        check("erro_pulso", s_erro, 0);
        check("ocioso_apos_erro", s_estado, 0);
        check("ocupado_apos_erro", s_ocupado, 0);
        return;
      end
      if (i == reinicio) begin
        zera_n = 1'b0;
        @(negedge clock);
        zera_n = 1'b1;
        check("reset_partida", s_partida, 0);
        check("reset_ocupado", s_ocupado, 0);
        check("reset_estado", s_estado, 0);
        check("reset_dado", s_dado, 0);
        check("reset_fim_erro", {s_fim, s_erro}, 0);
        visto = 1'b0;
        repeat (30) begin
          @(negedge clock);
          visto = visto | s_fim | s_erro | s_partida;
        end
        check("pos_reset_quieto", visto, 0);
        return;
      end
      repeat (dly - 1) @(negedge clock);
      if (muda && i == 4) begin
        medidas_a = 36'({$urandom, $urandom});
        iniciar   = 1'b1;
        @(negedge clock);
        iniciar   = 1'b0;
      end
      check("dado_estavel", s_dado, exp_q[i]);
      pronto = 1'b1;
      @(negedge clock);
      pronto = 1'b0;
    end
    check("fim", s_fim, 1);
    check("estado_fim", s_estado, 3);
    check("ocupado_fim", s_ocupado, 0);
    @(negedge clock);
    check("fim_pulso", s_fim, 0);
    check("ocioso", s_estado, 0);
    check("sem_reinicio", s_partida, 0);
  endtask

  initial begin
    zera_n    = 1'b0;
    iniciar   = 1'b0;
    pronto    = 1'b0;
    sel       = 1'b0;
    medidas_a = '0;
    medidas_b = '0;
    repeat (3) @(negedge clock);
    check("rst_partida", s_partida, 0);
    check("rst_dado", s_dado, 0);
    check("rst_ocupado", s_ocupado, 0);
    check("rst_fim_erro", {s_fim, s_erro}, 0);
    check("rst_estado", s_estado, 0);
    sel = 1'b1;
    check("rst_estado_b", s_estado, 0);
    check("rst_dado_b", s_dado, 0);
    sel = 1'b0;
    zera_n = 1'b1;
    @(negedge clock);

    // Directed frame with a literal expected byte list
    medidas_a = {12'h000, 12'h1F0, 12'h0A3};
`ifdef TELEMETRIA_CHECKSUM_EN
    exp_q = '{8'h30, 8'h41, 8'h33, 8'h2C, 8'h31, 8'h46, 8'h30, 8'h2C,
              8'h30, 8'h30, 8'h30, 8'h33, 8'h35, 8'h23};
`else
    exp_q = '{8'h30, 8'h41, 8'h33, 8'h2C, 8'h31, 8'h46, 8'h30, 8'h2C,
              8'h30, 8'h30, 8'h30, 8'h23};
`endif
    run_frame(5, 1'b0, -1, -1);

    for (int f = 0; f < 5; f++) begin
      medidas_a = 36'({$urandom, $urandom});
      build(64'(medidas_a), 3, 3);
      run_frame(int'($urandom_range(1, 4)), 1'b0, -1, -1);
      repeat (int'($urandom_range(0, 3))) @(negedge clock);
    end

    // Snapshot isolation: medidas change and iniciar pulse mid-frame
    medidas_a = 36'({$urandom, $urandom});
    build(64'(medidas_a), 3, 3);
    run_frame(3, 1'b1, -1, -1);

    // Timeout on the third byte
    medidas_a = 36'({$urandom, $urandom});
    build(64'(medidas_a), 3, 3);
    run_frame(2, 1'b0, 2, -1);

    // Reset during the fifth byte
    medidas_a = 36'({$urandom, $urandom});
    build(64'(medidas_a), 3, 3);
    run_frame(2, 1'b0, -1, 4);

    // Single channel, four digits
    sel = 1'b1;
    medidas_b = 16'hFFFF;
`ifdef TELEMETRIA_CHECKSUM_EN
    exp_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h30, 8'h30, 8'h23};
`else
    exp_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h23};
`endif
    run_frame(5, 1'b0, -1, -1);
    for (int f = 0; f < 3; f++) begin
      medidas_b = 16'($urandom);
      build(64'(medidas_b), 1, 4);
      run_frame(int'($urandom_range(1, 4)), 1'b0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
